seq_barrel_shifter: RTL and testbench

//  Multi-cycle barrel shifter for the ALU shift path. Supports SLL/SRL/SRA/ROL/ROR.

---
 rtl/alu_shift_pkg.sv | 35 +++
 rtl/shift_stage_mux.sv | 20 ++
 rtl/seq_barrel_shifter.sv | 148 ++++++++++++++
 tb/tb_seq_barrel_shifter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift path: op encodings, FSM states and a
// bit-reversal helper used to map left operations onto a right-only datapath.
package alu_shift_pkg;

    typedef enum logic [2:0] {
        SHOP_SLL = 3'b000,
        SHOP_SRL = 3'b001,
        SHOP_SRA = 3'b010,
        SHOP_ROL = 3'b011,
        SHOP_ROR = 3'b100
    } shop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest operand bitrev can handle; callers zero-extend narrower values.
    localparam int BITREV_MAX = 64;

    // Reverses the low 'width' bits of value; bits above 'width' return as 0.
    function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] value,
                                                     input int width);
        logic [BITREV_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX; i++) begin
            if (i < width) begin
                r[i] = value[6'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// One right-shift stage of the barrel shifter: passes data through or shifts it
// right by SHIFT_AMT, either wrapping the low bits (rotate) or filling with fill_bit.
module shift_stage_mux #(
    parameter int WIDTH     = 32,
    parameter int SHIFT_AMT = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             do_shift,
    input  logic             rotate,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shifted;

    assign shifted  = rotate ? {data_in[SHIFT_AMT-1:0], data_in[WIDTH-1:SHIFT_AMT]}
                             : {{SHIFT_AMT{fill_bit}}, data_in[WIDTH-1:SHIFT_AMT]};
    assign data_out = do_shift ? shifted : data_in;

endmodule

// File: rtl/seq_barrel_shifter.sv
// Multi-cycle barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready on both sides.
// STAGES_PER_CYCLE log2 stages are applied per RUN cycle; a final cycle registers the result.
module seq_barrel_shifter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int STAGES_PER_CYCLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);

    localparam int LOG2W  = $clog2(WIDTH);
    localparam int SPC    = STAGES_PER_CYCLE;
    localparam int N_ITER = (LOG2W + SPC - 1) / SPC;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    state_e           state_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic [2:0]       op_reg;
    logic [LOG2W-1:0] amt_reg;
    logic             fill_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             accept;
    logic             entry_rev;
    logic             entry_fill;
    logic [WIDTH-1:0] entry_work;
    logic             op_legal;
    logic             rotate_op;
    logic             exit_rev;
    logic [WIDTH-1:0] exit_data;
    logic [WIDTH-1:0] iter_out;

    logic [WIDTH-1:0] stage_in  [LOG2W];
    logic [WIDTH-1:0] stage_out [LOG2W];
    logic [WIDTH-1:0] grp_out   [N_ITER];

    assign in_ready = !rst && ((state_reg == ST_IDLE) ||
                               ((state_reg == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Left ops enter and leave bit-reversed so the stages only ever shift right.
    assign entry_rev  = (in_op == SHOP_SLL) || (in_op == SHOP_ROL);
    assign entry_fill = (in_op == SHOP_SRA) && in_data[WIDTH-1];
    assign entry_work = entry_rev ? WIDTH'(bitrev(BITREV_MAX'(in_data), WIDTH)) : in_data;

    // Reserved codes never enable a stage, so the operand passes through unchanged.
    assign op_legal  = (op_reg <= SHOP_ROR);
    assign rotate_op = (op_reg == SHOP_ROL) || (op_reg == SHOP_ROR);
    assign exit_rev  = (op_reg == SHOP_SLL) || (op_reg == SHOP_ROL);
    assign exit_data = exit_rev ? WIDTH'(bitrev(BITREV_MAX'(work_reg), WIDTH)) : work_reg;

    // Stages are chained within a group of SPC; every group starts from work_reg.
    generate
        for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
            if ((gi % SPC) == 0) begin : g_head
                assign stage_in[gi] = work_reg;
            end else begin : g_chain
                assign stage_in[gi] = stage_out[gi-1];
            end

            shift_stage_mux #(
                .WIDTH     (WIDTH),
                .SHIFT_AMT (2 ** gi)
            ) u_stage (
                .data_in  (stage_in[gi]),
                .do_shift (amt_reg[gi] && op_legal),
                .rotate   (rotate_op),
                .fill_bit (fill_reg),
                .data_out (stage_out[gi])
            );
        end

        for (genvar gi = 0; gi < N_ITER; gi++) begin : g_group
            localparam int LAST = (gi * SPC + SPC - 1 < LOG2W) ? (gi * SPC + SPC - 1)
                                                               : (LOG2W - 1);
            assign grp_out[gi] = stage_out[LAST];
        end
    endgenerate

    always_comb begin
        iter_out = work_reg;
        for (int i = 0; i < N_ITER; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                iter_out = grp_out[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            work_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            op_reg        <= 3'b000;
            amt_reg       <= '0;
            fill_reg      <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_RUN: begin
                    if (cnt_reg == CNT_W'(N_ITER)) begin
                        out_data_reg  <= exit_data;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        work_reg <= iter_out;
                        cnt_reg  <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Accept is only possible from IDLE or from DONE being drained.
            if (accept) begin
                work_reg  <= entry_work;
                op_reg    <= in_op;
                amt_reg   <= in_amt;
                fill_reg  <= entry_fill;
                cnt_reg   <= '0;
                state_reg <= ST_RUN;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Self-checking bench for seq_barrel_shifter: directed corner cases plus random
// traffic, scored against an arithmetic model of the shift operations.
module tb_seq_barrel_shifter;

    localparam int W       = 32;
    localparam int N_ITER  = 3;
    localparam int LATENCY = N_ITER + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_data = 32'd0;
    logic [4:0]  in_amt = 5'd0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic        rnd_ready = 1'b1;
    int          cyc = 0;
    logic        rst_q = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          txn = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;

    assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

    seq_barrel_shifter #(.WIDTH(W), .STAGES_PER_CYCLE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input int n);
        logic [31:0] r;
        case (op)
            3'd0: r = x << n;
            3'd1: r = x >> n;
            3'd2: r = $signed(x) >>> n;
            3'd3: r = (n == 0) ? x : ((x << n) | (x >> (32 - n)));
            3'd4: r = (n == 0) ? x : ((x >> n) | (x << (32 - n)));
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                check_eq("rst_in_ready", 32'(in_ready), 32'd0);
            end
            if (rst_q) begin
                check_eq("rst_out_valid", 32'(out_valid), 32'd0);
                check_eq("rst_out_data", out_data, 32'd0);
            end
            if (!rst && !rst_q && out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check_eq("out_data", out_data, exp_q[0]);
                    if (!prev_valid || prev_hs) begin
                        check_eq("latency", 32'(cyc - acc_q[0]), 32'(LATENCY));
                    end
                    if (!out_ready) begin
                        check_eq("in_ready_stall", 32'(in_ready), 32'd0);
                    end else begin
                        $display("txn %0d result=%h", txn, out_data);
                        txn++;
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            if (!rst && in_valid && in_ready) begin
                exp_q.push_back(model(in_op, in_data, int'(in_amt)));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    // Drives one request; returns after the accepting edge with inputs scrambled.
    task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                        output int tries);
        logic got;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_valid = 1'b1;
        got      = 1'b0;
        tries    = 0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            tries++;
            if (in_ready) got = 1'b1;
        end
        check_eq("send_accepted", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_data  = $urandom;
        in_amt   = 5'($urandom);
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        check_eq("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 64 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("out_valid_rise", 32'(seen), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;

        check_eq("model_sll", model(3'd0, 32'h0000_0001, 31), 32'h8000_0000);
        check_eq("model_sra", model(3'd2, 32'h8000_0000, 4),  32'hF800_0000);
        check_eq("model_srl", model(3'd1, 32'h8000_0000, 4),  32'h0800_0000);
        check_eq("model_ror", model(3'd4, 32'h1234_5678, 8),  32'h7812_3456);
        check_eq("model_rol", model(3'd3, 32'h8000_0001, 1),  32'h0000_0003);
        check_eq("model_rsv", model(3'd7, 32'hDEAD_BEEF, 5),  32'hDEAD_BEEF);
        check_eq("model_sra31", model(3'd2, 32'h8000_0000, 31), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        ready_mode = 1;
        send(3'd0, 32'h0000_0001, 5'd31, tries);
        send(3'd2, 32'h8000_0000, 5'd4, tries);
        send(3'd1, 32'h8000_0000, 5'd4, tries);
        send(3'd4, 32'h1234_5678, 5'd8, tries);
        send(3'd3, 32'h8000_0001, 5'd1, tries);
        send(3'd2, 32'h8000_0000, 5'd31, tries);
        send(3'd7, 32'hDEAD_BEEF, 5'd5, tries);
        for (int op = 0; op < 8; op++) begin
            send(3'(op), 32'hA5C3_0F96, 5'd0, tries);
        end
        wait_drain();

        // Hold the consumer off in DONE, then release it with a new request waiting.
        ready_mode = 0;
        send(3'd1, 32'h8000_0000, 5'd4, tries);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            check_eq("stall_out_data", out_data, 32'h0800_0000);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        send(3'd4, 32'h1234_5678, 5'd8, tries);
        check_eq("b2b_same_cycle", 32'(tries), 32'd1);
        wait_drain();

        // Reset pulsed during the second RUN cycle discards the operation.
        send(3'd0, 32'h0000_00FF, 5'd12, tries);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        send(3'd2, 32'h9000_0000, 5'd3, tries);
        wait_drain();

        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            send(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), tries);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
